// File: rtl/apb_modport_slave.sv
// ---------------------------------------------------------------------------
// apb_modport_slave
//
// APB completer holding DEPTH 32-bit registers starting at BASE_ADDR.
// A transfer is framed by a setup phase (penable low) and an access phase
// (penable high). The access is captured on the first edge in IDLE that sees
// penable high. After WAIT_STATES extra cycles, pready pulses for one cycle
// together with prdata/presp. The FSM then waits in HOLD until penable drops,
// so a held penable never completes a second time.
//
// Handshake: a transfer starts on the rising edge where penable=1 and the
// FSM is idle. It completes in the single cycle where pready=1. prdata and
// presp are meaningful only in that cycle and read as zero at all other times.
//
// Ports:
//   pclk       in   clock, rising edge
//   prst       in   synchronous active-high reset
//   paddr      in   32-bit byte address
//   pwrite     in   1 = write, 0 = read
//   pwdata     in   32-bit write data
//   penable    in   access phase indicator
//   pready     out  one-cycle completion pulse (registered)
//   prdata     out  read data, valid while pready=1 (registered)
//   presp      out  00 OKAY / 01 SLVERR, valid while pready=1 (registered)
//   dbg_state  out  current FSM state (0 IDLE, 1 WAIT, 2 RESP, 3 HOLD)
// ---------------------------------------------------------------------------
module apb_modport_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        pclk,
   input  logic        prst,
   input  logic [31:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   input  logic        penable,
   output logic        pready,
   output logic [31:0] prdata,
   output logic [1:0]  presp,
   output logic [1:0]  dbg_state
);

   localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] regs_q [DEPTH];

   logic        pready_q, pready_d;
   logic [31:0] prdata_q, prdata_d;
   logic [1:0]  presp_q, presp_d;

   // Access seen by decode. With zero wait states the completion edge is
   // the capture edge, so the live bus is used. Otherwise the captured copy
   // is used.
   logic [31:0]     acc_addr;
   logic            acc_write;
   logic [31:0]     acc_wdata;
   logic [31:0]     offset;
   logic            acc_legal;
   logic [IDXW-1:0] acc_idx;
   logic            enter_resp;
   logic            do_write;

   always_comb begin
      acc_addr  = addr_q;
      acc_write = write_q;
      acc_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         acc_addr  = paddr;
         acc_write = pwrite;
         acc_wdata = pwdata;
      end
   end

   // The offset wraps for addresses below BASE_ADDR. The explicit >= test
   // rejects them.
   assign offset     = acc_addr - BASE_ADDR;
   assign acc_legal  = (acc_addr[1:0] == 2'b00) && (acc_addr >= BASE_ADDR) && (offset < SPAN);
   assign acc_idx    = offset[IDXW+1:2];
   assign enter_resp = (state_d == S_RESP);
   assign do_write   = enter_resp && acc_legal && acc_write;

   // State register
   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (penable) begin
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end
         end
         S_WAIT: begin
            // penable is ignored here; a started transfer always completes
            if (cnt_q <= 4'd1) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_HOLD;
         S_HOLD:  if (!penable) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic, computed for the next cycle so every output is a flop
   always_comb begin
      pready_d = enter_resp;
      presp_d  = 2'b00;
      prdata_d = '0;
      if (enter_resp) begin
         if (!acc_legal)     presp_d  = 2'b01;
         else if (!acc_write) prdata_d = regs_q[acc_idx];
      end
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         pready_q <= 1'b0;
         prdata_q <= '0;
         presp_q  <= 2'b00;
      end else begin
         pready_q <= pready_d;
         prdata_q <= prdata_d;
         presp_q  <= presp_d;
      end
   end

   // Register bank. A pending write is dropped when reset hits.
   always_ff @(posedge pclk) begin
      if (prst) begin
         for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      end else if (do_write) begin
         regs_q[acc_idx] <= acc_wdata;
      end
   end

   assign pready    = pready_q;
   assign prdata    = prdata_q;
   assign presp     = presp_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_modport_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_modport_slave
//
// Two instances share one clock and reset. Index 0 uses WAIT_STATES=0 and
// index 1 uses WAIT_STATES=3. A per-instance register-array model predicts
// every response. Each expectation is queued before its transfer and popped
// when the completion cycle is reached.
// ---------------------------------------------------------------------------
module tb_apb_modport_slave;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 16;

   // clock / reset
   logic pclk = 1'b0;
   logic prst = 1'b1;
   always #5 pclk = ~pclk;

   logic [31:0] paddr   [2];
   logic        pwrite  [2];
   logic [31:0] pwdata  [2];
   logic        penable [2];
   logic        pready  [2];
   logic [31:0] prdata  [2];
   logic [1:0]  presp   [2];
   logic [1:0]  dbg     [2];

   apb_modport_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .pclk(pclk), .prst(prst), .paddr(paddr[0]), .pwrite(pwrite[0]),
      .pwdata(pwdata[0]), .penable(penable[0]), .pready(pready[0]),
      .prdata(prdata[0]), .presp(presp[0]), .dbg_state(dbg[0])
   );

   apb_modport_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
      .pclk(pclk), .prst(prst), .paddr(paddr[1]), .pwrite(pwrite[1]),
      .pwdata(pwdata[1]), .penable(penable[1]), .pready(pready[1]),
      .prdata(prdata[1]), .presp(presp[1]), .dbg_state(dbg[1])
   );

   // scoreboard
   logic [33:0] exp_q[$];          // {presp, prdata}
   logic [31:0] mem [2][DEPTH];    // reference register banks
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit model_legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
   endtask

   // One full transfer: setup, access, wait states, completion, hold, release.
   task automatic xfer(input int d, input logic [31:0] a, input logic wr,
                       input logic [31:0] wd, input int hold, input bit drop_early,
                       output logic [31:0] rd);
      logic [33:0] ex;
      int          w;
      int          idx;
      w = ws_of(d);
      if (!model_legal(a)) begin
         exp_q.push_back({2'b01, 32'h0});
      end else begin
         idx = int'((a - BASE) >> 2);
         if (wr) begin
            mem[d][idx] = wd;
            exp_q.push_back({2'b00, 32'h0});
         end else begin
            exp_q.push_back({2'b00, mem[d][idx]});
         end
      end
      @(negedge pclk);
      paddr[d] = a; pwrite[d] = wr; pwdata[d] = wd; penable[d] = 1'b0;
      @(negedge pclk);
      penable[d] = 1'b1;
      for (int k = 0; k <= w; k++) begin
         @(negedge pclk);
         if (k < w) check("wait_rdy", 32'(pready[d]), 32'd0);
         if (k == w) begin
            ex = exp_q.pop_front();
            check("rdy", 32'(pready[d]), 32'd1);
            check("resp", 32'(presp[d]), 32'(ex[33:32]));
            check("rdata", prdata[d], ex[31:0]);
            rd = prdata[d];
         end
         // After capture, bus changes must not affect the transfer.
         if (k == 0) begin
            paddr[d]  = $urandom;
            pwdata[d] = $urandom;
            pwrite[d] = 1'($urandom_range(0, 1));
            if (drop_early) penable[d] = 1'b0;
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge pclk);
         check("no_dbl", 32'(pready[d]), 32'd0);
      end
      penable[d] = 1'b0;
      @(negedge pclk);
      check("post_rdy", 32'(pready[d]), 32'd0);
      check("post_resp", 32'(presp[d]), 32'd0);
      check("post_rdata", prdata[d], 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge pclk);
      prst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge pclk);
         check("rst_rdy0", 32'(pready[0]), 32'd0);
         check("rst_rdy3", 32'(pready[1]), 32'd0);
      end
      prst = 1'b0;
      model_clear();
   endtask

   logic [31:0] rd;
   logic [31:0] a;
   int          r;

   initial begin
      for (int d = 0; d < 2; d++) begin
         paddr[d] = '0; pwrite[d] = 1'b0; pwdata[d] = '0; penable[d] = 1'b0;
      end
      model_clear();

      // reset and post-reset reads
      do_reset(2);
      for (int d = 0; d < 2; d++) begin
         check("rst_rdata", prdata[d], 32'd0);
         check("rst_resp", 32'(presp[d]), 32'd0);
         xfer(d, 32'h00, 1'b0, 32'h0, 0, 1'b0, rd);
         check("rst_rd00", rd, 32'd0);
         xfer(d, 32'h3C, 1'b0, 32'h0, 0, 1'b0, rd);
         check("rst_rd3c", rd, 32'd0);
      end

      // write/read, zero wait states
      xfer(0, 32'h08, 1'b1, 32'hA5A5_1234, 0, 1'b0, rd);
      xfer(0, 32'h08, 1'b0, 32'h0, 0, 1'b0, rd);
      check("wr_rd08", rd, 32'hA5A5_1234);

      // wait states with penable held high
      xfer(1, 32'h04, 1'b1, 32'h1, 3, 1'b0, rd);
      xfer(1, 32'h04, 1'b0, 32'h0, 2, 1'b0, rd);
      check("ws_rd04", rd, 32'h1);

      // illegal accesses leave registers alone
      for (int d = 0; d < 2; d++) begin
         xfer(d, 32'h00, 1'b1, 32'hCAFE_0000, 0, 1'b0, rd);
         xfer(d, 32'h40, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, rd);
         xfer(d, 32'h06, 1'b1, 32'hDEAD_BEEF, 1, 1'b0, rd);
         xfer(d, 32'h00, 1'b0, 32'h0, 0, 1'b0, rd);
         check("err_rd00", rd, 32'hCAFE_0000);
         xfer(d, 32'h04, 1'b0, 32'h0, 0, 1'b0, rd);
         check("err_rd04", rd, (d == 0) ? 32'h0 : 32'h1);
      end

      // back-to-back
      xfer(0, 32'h00, 1'b1, 32'h11, 0, 1'b0, rd);
      xfer(0, 32'h04, 1'b1, 32'h22, 0, 1'b0, rd);
      xfer(0, 32'h3C, 1'b1, 32'h33, 0, 1'b0, rd);
      xfer(0, 32'h00, 1'b0, 32'h0, 0, 1'b0, rd);
      check("b2b_rd00", rd, 32'h11);
      xfer(0, 32'h04, 1'b0, 32'h0, 0, 1'b0, rd);
      check("b2b_rd04", rd, 32'h22);
      xfer(0, 32'h3C, 1'b0, 32'h0, 0, 1'b0, rd);
      check("b2b_rd3c", rd, 32'h33);

      // penable dropped during WAIT still completes
      xfer(1, 32'h20, 1'b1, 32'h5555_AAAA, 0, 1'b1, rd);
      xfer(1, 32'h20, 1'b0, 32'h0, 0, 1'b1, rd);
      check("drop_rd20", rd, 32'h5555_AAAA);

      // reset in the middle of a waited write
      @(negedge pclk);
      paddr[1] = 32'h10; pwrite[1] = 1'b1; pwdata[1] = 32'hFFFF_FFFF; penable[1] = 1'b0;
      @(negedge pclk);
      penable[1] = 1'b1;
      @(negedge pclk);
      check("mid_wait_rdy", 32'(pready[1]), 32'd0);
      prst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge pclk);
         check("mid_rst_rdy", 32'(pready[1]), 32'd0);
      end
      prst = 1'b0;
      penable[1] = 1'b0;
      model_clear();
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         check("mid_after_rdy", 32'(pready[1]), 32'd0);
      end
      xfer(1, 32'h10, 1'b0, 32'h0, 0, 1'b0, rd);
      check("mid_rd10", rd, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         else if (r < 8) a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         else if (r < 9) a = {24'h0, 6'($urandom_range(16, 63)), 2'b00};
         else            a = $urandom;
         xfer(n % 2, BASE + a, 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
